unidade_mult_div: RTL and testbench
===================================

# unidade_mult_div

Iterative multiply/divide unit for the MIPS datapath, placed directly downstream of the register bank. It consumes the two source operand outputs of the register bank on a start pulse and executes MULT, MULTU, DIV or DIVU over multiple cycles. Results go into internal HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. The pipeline control stalls on `busy`.

## Interface
- `LARGURA`, 32, operand/HI/LO width; the iteration count equals `LARGURA`
- `clock`  in  1  clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  launches operation; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `operando_a`  in  LARGURA  rs value (multiplicand / dividend)
- `operando_b`  in  LARGURA  rt value (multiplier / divisor)
- `wr_hi`  in  1  MTHI write strobe
- `wr_lo`  in  1  MTLO write strobe
- `data_in`  in  LARGURA  MTHI/MTLO data
- `busy`  out  1  high while an operation is in flight
- `done`  out  1  one-cycle pulse when HI/LO receive a new result
- `hi`  out  LARGURA  HI register (upper product / remainder)
- `lo`  out  LARGURA  LO register (lower product / quotient)

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 latches `op`, |a| and |b| into internal registers, plus the result signs: signed ops use two's-complement magnitude, unsigned ops use raw values.
  - Clears the iteration counter and goes to CALC.
- CALC:
  - One iteration per cycle; `LARGURA` iterations, then FIX.
  - Multiply: shift-add over a 2·LARGURA accumulator.
  - Divide: restoring division; each cycle shifts the remainder left one bit and subtracts the divisor; if the result is non-negative, keep it and set the quotient bit.
- FIX:
  - Applies the sign correction.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: the quotient is negative if the signs differ; the remainder takes the sign of the dividend.
  - Writes HI/LO, pulses `done`, returns to IDLE.
- Division by zero (`operando_b`=0, DIV or DIVU): LO=all ones, HI=`operando_a` as sampled (raw, unsigned view).
- DIV overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Operands are sampled only at the start edge; input changes afterwards have no effect.
- MTHI/MTLO:
  - In IDLE, `wr_hi`/`wr_lo` load `data_in` into HI/LO on the next edge; both may be asserted together.
  - Writes are ignored while `busy`=1.
  - If `start` and a write occur in the same IDLE cycle, `start` wins and the write is discarded.
- `start` while `busy`=1 is ignored (no queueing).
- `hi`/`lo` hold their old value for the whole operation and change only at the FIX edge or on an accepted write.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter and internal registers 0. Takes effect immediately, including mid-operation; the partial result is discarded.
- Edge E0 samples `start`=1. `busy`=1 from after E0.
- Iterations run on E1..E`LARGURA`. The FIX edge is E`LARGURA`+1, which updates `hi`/`lo`.
- After that edge: `done`=1 and `busy`=0 for exactly one cycle. Latency from the start edge to valid HI/LO is `LARGURA`+1 edges (33 for 32-bit).
- A new `start` may be asserted in the cycle `done`=1; it is accepted at that edge.
- `busy`, `done`, `hi` and `lo` are registered outputs; there is no combinational path from the inputs.

## Configuration
- `MULT_DIV_ZERO_BYPASS_EN`:
  - Defined: DIV/DIVU with `operando_b`=0 skips CALC and goes IDLE→FIX. The result is written at E1, with `done` high after E1, `busy` high for one cycle only.
  - Undefined: divide-by-zero runs the full `LARGURA`+1 edge latency. Result values are identical either way.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - `done` is seen 33 edges after start.
  - HI=0xFFFFFFFE, LO=0x00000001; `busy` is high exactly 33 cycles.
- MULT −3 × 7: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x1234. Done latency:
  - 1 edge with `MULT_DIV_ZERO_BYPASS_EN` defined.
  - 33 edges without it.
- Protocol checks:
  - MTHI 0xA5A5A5A5 in IDLE → HI updates on the next edge.
  - `wr_lo` and a second `start` pulsed mid-operation are both ignored.
  - `reset_n` low at iteration 10 → `busy`=0, HI=LO=0 immediately.
  - After release, a new MULTU 6×7 gives LO=42.

Source files
------------

// File: rtl/unidade_mult_div.sv
// unidade_mult_div: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Optional `MULT_DIV_ZERO_BYPASS_EN sends divide-by-zero straight to FIX.
module unidade_mult_div #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [LARGURA-1:0] operando_a,
  input  logic [LARGURA-1:0] operando_b,
  input  logic               wr_hi,
  input  logic               wr_lo,
  input  logic [LARGURA-1:0] data_in,
  output logic               busy,
  output logic               done,
  output logic [LARGURA-1:0] hi,
  output logic [LARGURA-1:0] lo
);
  localparam int W  = LARGURA;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, acc_n, prod;
  logic [W-1:0] m, raw_a, abs_a, abs_b, q, r, hi_fix, lo_fix;
  logic [W:0] sum, shl, diff;
  logic is_div, dz, neg_q, neg_r, sa, sb, zero_b, go, byp;
  assign sa     = ~op[0] & operando_a[W-1];
  assign sb     = ~op[0] & operando_b[W-1];
  assign abs_a  = sa ? -operando_a : operando_a;
  assign abs_b  = sb ? -operando_b : operando_b;
  assign zero_b = operando_b == '0;
  assign go     = state == IDLE && start;
`ifdef MULT_DIV_ZERO_BYPASS_EN
  assign byp = op[1] & zero_b;
`else
  assign byp = 1'b0;
`endif
  // acc holds {upper product, multiplier} for multiply, {remainder, quotient} for divide
  assign sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : '0);
  assign shl   = {acc[2*W-1:W], acc[W-1]};
  assign diff  = shl - {1'b0, m};
  assign acc_n = is_div ? (diff[W] ? {shl[W-1:0], acc[W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1})
                        : {sum, acc[W-1:1]};
  assign prod   = neg_q ? -acc : acc;
  assign q      = acc[W-1:0];
  assign r      = acc[2*W-1:W];
  assign hi_fix = is_div ? (dz ? raw_a : (neg_r ? -r : r)) : prod[2*W-1:W];
  assign lo_fix = is_div ? (dz ? '1 : (neg_q ? -q : q)) : prod[W-1:0];
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (start ? (byp ? FIX : CALC) : IDLE)
            : state == CALC ? (cnt == CW'(W - 1) ? FIX : CALC)
            : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      raw_a  <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= state_n != IDLE;
      done  <= state == FIX;
      cnt   <= state == CALC ? cnt + 1'b1 : '0;
      if (go) begin
        is_div <= op[1];
        dz     <= op[1] & zero_b;
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        raw_a  <= operando_a;
        m      <= op[1] ? abs_b : abs_a;
        acc    <= {{W{1'b0}}, op[1] ? abs_a : abs_b};
      end else if (state == CALC) begin
        acc <= acc_n;
      end
      if (state == FIX) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end else if (state == IDLE && !start) begin
        if (wr_hi) hi <= data_in;
        if (wr_lo) lo <= data_in;
      end
    end
  end
endmodule

// File: tb/tb_unidade_mult_div.sv
// tb_unidade_mult_div: directed vectors with a scoreboard queue and a done-driven monitor.
module tb_unidade_mult_div;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int lat;} exp_t;
`ifdef MULT_DIV_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  logic clock = 0, reset_n = 0, start = 0, wr_hi = 0, wr_lo = 0;
  logic [1:0] op = 0;
  logic [31:0] operando_a = 0, operando_b = 0, data_in = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  exp_t sb_q[$];
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, busy_cyc = 0;

  unidade_mult_div #(.LARGURA(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operando_a(operando_a), .operando_b(operando_b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .data_in(data_in),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && busy) busy_cyc++;
    if (reset_n && done) begin
      if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    e.hi = eh; e.lo = el; e.lat = lat;
    if (push) sb_q.push_back(e);
    op = o; operando_a = a; operando_b = b; start = 1;
    @(posedge clock);
    #1;
    start_cyc = cyc;
    busy_cyc = 0;
    start = 0;
    operando_a = 32'h5555_AAAA; operando_b = 32'h0F0F_0F0F; op = ~o;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int lat);
    @(negedge clock);
    launch(o, a, b, 1, eh, el, lat);
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset_n = 1;
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    chk("busy_cycles", 32'(busy_cyc), 32'd33);
    run(2'b00, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    run(2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    run(2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, ZLAT);
    chk("dz_busy_cycles", 32'(busy_cyc), 32'(ZLAT));
    run(2'b10, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, ZLAT);
    @(negedge clock);
    wr_hi = 1; data_in = 32'hA5A5_A5A5;
    @(negedge clock);
    wr_hi = 0;
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);
    wr_hi = 1; wr_lo = 1; data_in = 32'h1357_9BDF;
    @(negedge clock);
    wr_hi = 0; wr_lo = 0;
    chk("both_hi", hi, 32'h1357_9BDF);
    chk("both_lo", lo, 32'h1357_9BDF);
    wr_lo = 1; data_in = 32'h0000_0BAD;
    launch(2'b01, 32'd6, 32'd7, 1, 32'd0, 32'd42, 33);
    wr_lo = 0;
    @(negedge clock);
    chk("start_beats_write", lo, 32'h1357_9BDF);
    wait_done();
    launch(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 33);
    wait_done();
    launch(2'b00, -32'sd3, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    wait_done();
    @(negedge clock);
    launch(2'b11, 32'd100, 32'd7, 1, 32'd2, 32'd14, 33);
    repeat (5) @(negedge clock);
    wr_lo = 1; data_in = 32'hDEAD_BEEF; start = 1; op = 2'b01; operando_a = 1; operando_b = 1;
    @(negedge clock);
    wr_lo = 0; start = 0;
    chk("midop_lo_hold", lo, 32'hFFFF_FFEB);
    chk("midop_hi_hold", hi, 32'hFFFF_FFFF);
    chk("midop_busy", {31'd0, busy}, 32'd1);
    wait_done();
    repeat (3) @(negedge clock);
    chk("idle_after_ignored_start", {31'd0, busy}, 32'd0);
    @(negedge clock);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, 32'd0, 0);
    repeat (10) @(negedge clock);
    reset_n = 0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clock);
    reset_n = 1;
    run(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 33);
    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
